// File: rtl/joy_scan_mux.sv
// rtl/joy_scan_mux.sv - time-multiplexed joystick port scanner with per-port debounce
module joy_scan_mux #(
  parameter int NUM_PORTS        = 4,
  parameter int NUM_BITS         = 6,
  parameter int SETTLE_CYCLES    = 4,
  parameter int DEBOUNCE_SAMPLES = 3,
  localparam int SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   swap_ports,
  input  logic [NUM_BITS-1:0]    joy_in,
  output logic [SEL_W-1:0]       joy_sel,
  output logic [NUM_PORTS*8-1:0] joy_out,
  output logic                   scan_done
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int DB_W  = (DEBOUNCE_SAMPLES > 1) ? $clog2(DEBOUNCE_SAMPLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_MAX      = DB_W'(DEBOUNCE_SAMPLES - 1);
  localparam logic [SEL_W-1:0] LAST_PORT   = SEL_W'(NUM_PORTS - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

  state_t             state_q, state_n;
  logic [SEL_W-1:0]   idx_q, idx_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               capture;

  logic [NUM_BITS-1:0] last_q   [NUM_PORTS];
  logic [DB_W-1:0]     stable_q [NUM_PORTS];
  logic [NUM_BITS-1:0] deb_q    [NUM_PORTS];
  logic [DB_W-1:0]     new_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SETTLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      scan_done <= 1'b0;
    end else begin
      state_q   <= state_n;
      idx_q     <= idx_n;
      cnt_q     <= cnt_n;
      scan_done <= capture && (idx_q == LAST_PORT);
    end
  end

  // Dropping enable always parks in IDLE with the index held, so resuming repeats a full settle.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    cnt_n   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_n = '0;
        if (enable) state_n = SETTLE;
      end
      SETTLE: begin
        if (!enable) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_n = SAMPLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      SAMPLE: begin
        state_n = enable ? SETTLE : IDLE;
        cnt_n   = '0;
        if (enable) begin
          capture = 1'b1;
          idx_n   = (idx_q == LAST_PORT) ? '0 : idx_q + SEL_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    new_cnt = '0;
    if (joy_in == last_q[idx_q])
      new_cnt = (stable_q[idx_q] == DB_MAX) ? DB_MAX : stable_q[idx_q] + DB_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        last_q[p]   <= '1;
        stable_q[p] <= '0;
        deb_q[p]    <= '1;
      end
    end else if (capture) begin
      last_q[idx_q]   <= joy_in;
      stable_q[idx_q] <= new_cnt;
      if (new_cnt == DB_MAX) deb_q[idx_q] <= joy_in;
    end
  end

  assign joy_sel = idx_q;

  // Slots 0 and 1 trade places under swap_ports; SRC collapses to p when there is only one port.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_slot
    localparam int SRC = (NUM_PORTS >= 2 && p < 2) ? 1 - p : p;
    logic [NUM_BITS-1:0] deb_sel;
    assign deb_sel = swap_ports ? deb_q[SRC] : deb_q[p];
    if (NUM_BITS < 8) begin : g_pad
      assign joy_out[p*8 +: 8] = {{(8 - NUM_BITS){1'b1}}, deb_sel};
    end else begin : g_full
      assign joy_out[p*8 +: 8] = deb_sel;
    end
  end

endmodule

// File: tb/tb_joy_scan_mux.sv
// tb/tb_joy_scan_mux.sv - scoreboard bench for joy_scan_mux
module tb_joy_scan_mux;
  localparam int NP = 4;
  localparam int NB = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic          swap_ports = 1'b0;
  logic [NB-1:0] joy_in;
  logic [1:0]    joy_sel;
  logic [31:0]   joy_out;
  logic          scan_done;

  logic [NB-1:0] port_val [NP];
  int            exp_cyc_q [$];
  logic [31:0]   exp_out_q [$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            frame_end = 0;

  assign joy_in = port_val[joy_sel];

  always #5 clk = ~clk;

  joy_scan_mux #(
    .NUM_PORTS(NP), .NUM_BITS(NB), .SETTLE_CYCLES(4), .DEBOUNCE_SAMPLES(3)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .swap_ports(swap_ports),
    .joy_in(joy_in), .joy_sel(joy_sel), .joy_out(joy_out), .scan_done(scan_done)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Port 1 alternates every frame so it never settles.
  task automatic start_frame(input int f, input logic [31:0] exp_o, input int stall);
    port_val[1] = f[0] ? 6'h3E : 6'h3F;
    frame_end += 20 + stall;
    exp_cyc_q.push_back(frame_end);
    exp_out_q.push_back(exp_o);
  endtask

  // Monitor: every scan_done pulse must match the next queued frame result.
  initial begin
    int          e_c;
    logic [31:0] e_o;
    forever begin
      @(posedge clk);
      #1;
      if (reset) cyc = 0;
      else cyc++;
      if (scan_done) begin
        if (exp_out_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_scan_done: got pulse at cycle %0d, expected none", cyc);
        end else begin
          e_c = exp_cyc_q.pop_front();
          e_o = exp_out_q.pop_front();
          check32("scan_done_cycle", cyc, e_c);
          check32("frame_joy_out", joy_out, e_o);
          check32("frame_joy_sel", {30'd0, joy_sel}, 32'd0);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int p = 0; p < NP; p++) port_val[p] = 6'h3F;
    repeat (3) @(negedge clk);
    check32("reset_joy_out", joy_out, 32'hFFFF_FFFF);
    check32("reset_joy_sel", {30'd0, joy_sel}, 32'd0);
    check32("reset_scan_done", {31'd0, scan_done}, 32'd0);
    reset = 1'b0;

    port_val[2] = 6'h3E;
    start_frame(1, 32'hFFFF_FFFF, 0);
    for (int i = 0; i < 20; i++) begin
      if (i % 5 == 0) check32("sel_step", {30'd0, joy_sel}, i / 5);
      @(negedge clk);
    end
    start_frame(2, 32'hFFFF_FFFF, 0);
    repeat (20) @(negedge clk);
    start_frame(3, 32'hFFFE_FFFF, 0);
    repeat (20) @(negedge clk);
    start_frame(4, 32'hFFFE_FFFF, 0);
    repeat (20) @(negedge clk);

    port_val[0] = 6'h3D;
    start_frame(5, 32'hFFFE_FFFF, 0);
    repeat (20) @(negedge clk);
    start_frame(6, 32'hFFFE_FFFF, 0);
    repeat (20) @(negedge clk);
    start_frame(7, 32'hFFFE_FFFD, 0);
    repeat (20) @(negedge clk);

    swap_ports = 1'b1;
    #1 check32("swap_on", joy_out, 32'hFFFE_FDFF);
    swap_ports = 1'b0;
    #1 check32("swap_off", joy_out, 32'hFFFE_FFFD);

    // Frame 8 is stretched by a 10-clock hold two clocks into port 1's settle.
    start_frame(8, 32'hFFFE_FFFD, 12);
    repeat (6) @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check32("hold_joy_sel", {30'd0, joy_sel}, 32'd1);
      check32("hold_joy_out", joy_out, 32'hFFFE_FFFD);
    end
    enable = 1'b1;
    repeat (5) @(negedge clk);
    check32("resume_before_sample", {30'd0, joy_sel}, 32'd1);
    @(negedge clk);
    check32("resume_after_sample", {30'd0, joy_sel}, 32'd2);
    repeat (10) @(negedge clk);

    port_val[3] = 6'h3B;
    start_frame(9, 32'hFFFE_FFFD, 0);
    repeat (20) @(negedge clk);
    start_frame(10, 32'hFFFE_FFFD, 0);
    repeat (20) @(negedge clk);

    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check32("midreset_joy_out", joy_out, 32'hFFFF_FFFF);
    check32("midreset_joy_sel", {30'd0, joy_sel}, 32'd0);
    check32("midreset_scan_done", {31'd0, scan_done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    frame_end = 0;

    start_frame(1, 32'hFFFF_FFFF, 0);
    repeat (20) @(negedge clk);
    start_frame(2, 32'hFFFF_FFFF, 0);
    repeat (20) @(negedge clk);
    start_frame(3, 32'hFBFE_FFFD, 0);
    repeat (20) @(negedge clk);

    check32("pending_frames", exp_out_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/joy_scan_mux.md
JOY_SCAN_MUX -- requirements
Module: joy_scan_mux

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4, giving the number of multiplexed joystick ports (legal range 1..4).
REQ-002 The block SHALL have parameter NUM_BITS, default 6, giving the active-low raw lines per port (legal range 1..8).
REQ-003 The block SHALL have parameter SETTLE_CYCLES, default 4, giving the clocks waited after a select change before sampling (legal range >=1).
REQ-004 The block SHALL have parameter DEBOUNCE_SAMPLES, default 3, giving the consecutive identical samples needed to update an output (legal range >=1).
REQ-005 Port clk: input, 1 bit, the single clock; all logic SHALL be clocked on its rising edge.
REQ-006 Port reset: input, 1 bit, synchronous active-high reset.
REQ-007 Port enable: input, 1 bit, scan run/hold control.
REQ-008 Port swap_ports: input, 1 bit, exchanges output slots 0 and 1.
REQ-009 Port joy_in: input, NUM_BITS bits, shared raw joystick lines, active-low.
REQ-010 Port joy_sel: output, SEL_W = max(1, clog2(NUM_PORTS)) bits, index of the port currently driven onto joy_in.
REQ-011 Port joy_out: output, NUM_PORTS*8 bits, debounced active-low state; slot p is joy_out[p*8+7:p*8].
REQ-012 Port scan_done: output, 1 bit, one-cycle pulse at completion of each full scan frame.

Function
REQ-013 The FSM SHALL have states IDLE, SETTLE and SAMPLE, with a port index register and a settle counter.
REQ-014 In SETTLE with enable high, the counter SHALL increment each cycle; on the cycle the counter equals SETTLE_CYCLES-1, the next state SHALL be SAMPLE.
REQ-015 SAMPLE SHALL last exactly one cycle, capturing joy_in at the clock edge that ends it; the FSM then SHALL advance the index (wrap NUM_PORTS-1 -> 0), clear the counter and return to SETTLE.
REQ-016 joy_sel SHALL equal the port index register; per-port period = SETTLE_CYCLES+1 clocks; frame = NUM_PORTS*(SETTLE_CYCLES+1) clocks.
REQ-017 scan_done SHALL be registered and high for exactly the one cycle following the SAMPLE of port NUM_PORTS-1.
REQ-018 enable low in SETTLE or SAMPLE SHALL move the FSM to IDLE on the next edge, discard any capture in that SAMPLE cycle, clear the counter and hold the index; joy_out SHALL hold.
REQ-019 From IDLE with enable high, the FSM SHALL enter SETTLE for the same port with the counter at 0, giving a full settle period.
REQ-020 Each port SHALL keep a last-sample register (NUM_BITS) and a stable counter cnt saturating at DEBOUNCE_SAMPLES-1.
REQ-021 On sample s for port p, new_cnt SHALL be min(cnt+1, DEBOUNCE_SAMPLES-1) if s == last, else 0; then last <= s and cnt <= new_cnt.
REQ-022 If new_cnt == DEBOUNCE_SAMPLES-1, debounced[p] SHALL be loaded with s in the same edge; with DEBOUNCE_SAMPLES=1, every sample SHALL update immediately.
REQ-023 Comparison and debounce SHALL operate on the full NUM_BITS vector; any single-bit change SHALL restart the count.
REQ-024 Slot p SHALL be driven as {(8-NUM_BITS) ones, debounced[p]}; unused upper bits SHALL be constant 1.
REQ-025 When swap_ports=1 and NUM_PORTS>=2, slots 0 and 1 SHALL be exchanged combinationally, effective the same cycle; with NUM_PORTS=1, swap_ports SHALL be ignored.

Reset
REQ-026 reset high SHALL override enable and set: state SETTLE, index 0, counter 0, joy_sel=0, scan_done=0, every last = all ones, every cnt = 0, every debounced = all ones (joy_out all ones).
REQ-027 reset mid-frame SHALL discard partial debounce progress; the scan SHALL restart at port 0 on the first cycle after reset deasserts.

Verification (NUM_PORTS=4, NUM_BITS=6, SETTLE_CYCLES=4, DEBOUNCE_SAMPLES=3, enable=1)
REQ-028 Release reset -> joy_out=32'hFFFFFFFF, joy_sel=0; joy_sel steps 0,1,2,3 every 5 clocks; scan_done high only at cycles 20, 40, 60...
REQ-029 Port 2 stable 6'b111110 -> joy_out[23:16]=8'hFE after the third port-2 sample (frame 3); other slots stay 8'hFF.
REQ-030 Port 1 alternating 6'b111110 / 6'b111111 each frame -> joy_out[15:8] stays 8'hFF indefinitely.
REQ-031 swap_ports=1, port 0 debounced to 6'b111101 -> joy_out[15:8]=8'hFD, joy_out[7:0]=8'hFF; swap_ports=0 -> reversed the same cycle.
REQ-032 enable low 2 clocks into port-1 SETTLE for 10 clocks -> joy_sel held at 1, no scan_done, joy_out unchanged; re-enable -> port-1 SAMPLE occurs 5 clocks later.
REQ-033 reset pulsed mid-frame with port 3 at cnt=1 -> joy_out all ones, joy_sel=0; port 3 requires three fresh samples to update.
